// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache and its refill controller:
// default bus widths, timeout counter width and refill FSM state encoding.
package icache_pkg;

  localparam int ADDR_W_DEF  = 10;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W       = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_FILL  = 3'd3;
  localparam logic [2:0] ST_RETRY = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;

endpackage

// File: rtl/icache_refill_ctrl.sv
// Single-outstanding miss handler for the 2-way icache: fetches one word over
// req/gnt + rvalid, pulses the cache update, then lets fetch replay and hit.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              cache_hit,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cache_update,
  output logic [DATA_W-1:0] cache_wdata,
  output logic              stall,
  output logic              mem_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             miss_start;
  logic             fetch_miss;

  assign fetch_miss = fetch_valid & ~cache_hit;
  assign miss_start = (state == ST_IDLE) & fetch_miss & ~flush;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (miss_start) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        // A granted request must be drained even if flushed, or the response
        // would later be mistaken for the next miss's data.
        if (mem_gnt)    state_nxt = flush ? ST_DRAIN : ST_WAIT;
        else if (flush) state_nxt = ST_IDLE;
      end
      ST_WAIT: begin
        if (mem_rvalid) state_nxt = flush ? ST_IDLE : ST_FILL;
        else if (flush) state_nxt = ST_DRAIN;
      end
      ST_FILL:  state_nxt = ST_RETRY;
      ST_RETRY: state_nxt = ST_IDLE;
      ST_DRAIN: begin
        if (mem_rvalid) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      mem_addr    <= '0;
      cache_wdata <= '0;
      wait_cnt    <= '0;
      mem_err     <= 1'b0;
    end else begin
      state <= state_nxt;

      if (miss_start) mem_addr <= fetch_addr;

      if (state == ST_WAIT && mem_rvalid && !flush) cache_wdata <= mem_rdata;

      // Saturating wait counter; mem_err latches once the limit is reached.
      if (state == ST_REQ && mem_gnt) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
        if (wait_cnt != TIMEOUT_C) wait_cnt <= wait_cnt + CNT_W'(1);
        else                       mem_err  <= 1'b1;
      end
    end
  end

  assign mem_req      = (state == ST_REQ);
  assign cache_update = (state == ST_FILL);

  assign stall = miss_start
               | (state == ST_REQ)
               | (state == ST_WAIT)
               | (state == ST_FILL)
               | ((state == ST_DRAIN) & fetch_miss);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed test of icache_refill_ctrl: hit, miss timing, delayed grant,
// flush/drain, timeout error and mid-miss reset.
module tb_icache_refill_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_addr;
  logic              cache_hit;
  logic              flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              cache_update;
  logic [DATA_W-1:0] cache_wdata;
  logic              stall;
  logic              mem_err;

  int n_assert = 0;
  int n_fail   = 0;

  bit mon_en = 0;
  int stall_cnt = 0;
  int upd_cnt   = 0;
  int req_cnt   = 0;

  icache_refill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(255)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_valid  (fetch_valid),
    .fetch_addr   (fetch_addr),
    .cache_hit    (cache_hit),
    .flush        (flush),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .cache_update (cache_update),
    .cache_wdata  (cache_wdata),
    .stall        (stall),
    .mem_err      (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at posedge+1, so the negedge sees a settled cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      stall_cnt += int'(stall);
      upd_cnt   += int'(cache_update);
      req_cnt   += int'(mem_req);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    fetch_valid = 1'b0;
    cache_hit   = 1'b0;
    flush       = 1'b0;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
  endtask

  task automatic mon_start();
    stall_cnt = 0;
    upd_cnt   = 0;
    req_cnt   = 0;
    mon_en    = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    fetch_addr = '0;
    idle_inputs();
    #12;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_update", 32'(cache_update), 32'd0);
    check("rst_wdata", cache_wdata, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    cyc();
    reset = 1'b0;

    // 1: hits never stall or request
    mon_start();
    for (int i = 0; i < 4; i++) begin
      fetch_valid = 1'b1;
      cache_hit   = 1'b1;
      fetch_addr  = 10'h100 + 10'(i);
      settle();
      check("hit_stall", 32'(stall), 32'd0);
      cyc();
    end
    mon_en = 1'b0;
    check("hit_req_cycles", 32'(req_cnt), 32'd0);

    // 2: miss 0x045, gnt with req, rvalid two cycles after gnt
    idle_inputs();
    cyc();
    mon_start();
    fetch_valid = 1'b1; cache_hit = 1'b0; fetch_addr = 10'h045;
    settle();
    check("m2_idle_stall", 32'(stall), 32'd1);
    cyc();                                   // REQ
    mem_gnt = 1'b1;
    settle();
    check("m2_req", 32'(mem_req), 32'd1);
    check("m2_addr", 32'(mem_addr), 32'h045);
    cyc();                                   // WAIT, 1 after gnt
    mem_gnt = 1'b0;
    settle();
    check("m2_wait_req", 32'(mem_req), 32'd0);
    cyc();                                   // WAIT, 2 after gnt
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    cyc();                                   // FILL
    mem_rvalid = 1'b0; mem_rdata = '0;
    settle();
    check("m2_fill_update", 32'(cache_update), 32'd1);
    check("m2_fill_wdata", cache_wdata, 32'hDEADBEEF);
    check("m2_fill_stall", 32'(stall), 32'd1);
    cyc();                                   // RETRY
    cache_hit = 1'b1;
    settle();
    check("m2_retry_stall", 32'(stall), 32'd0);
    check("m2_retry_update", 32'(cache_update), 32'd0);
    cyc();                                   // IDLE, hit
    settle();
    check("m2_idle_req", 32'(mem_req), 32'd0);
    cyc();
    mon_en = 1'b0;
    check("m2_stall_cycles", 32'(stall_cnt), 32'd5);
    check("m2_update_cycles", 32'(upd_cnt), 32'd1);

    // 3: grant delayed 3 cycles, fetch_addr wanders meanwhile
    idle_inputs();
    fetch_valid = 1'b1; fetch_addr = 10'h2A7;
    cyc();                                   // REQ
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 10'h3FF - 10'(i);
      settle();
      check("m3_req_held", 32'(mem_req), 32'd1);
      check("m3_addr_stable", 32'(mem_addr), 32'h2A7);
      cyc();
    end
    mem_gnt = 1'b1;
    settle();
    check("m3_req_gnt", 32'(mem_req), 32'd1);
    check("m3_addr_gnt", 32'(mem_addr), 32'h2A7);
    cyc();                                   // WAIT
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    cyc();                                   // FILL
    mem_rvalid = 1'b0;
    settle();
    check("m3_fill_wdata", cache_wdata, 32'h12345678);
    check("m3_fill_update", 32'(cache_update), 32'd1);
    cyc();                                   // RETRY
    fetch_valid = 1'b0;
    cyc();                                   // IDLE

    // 4: flush in WAIT, response drained and discarded
    mon_start();
    fetch_valid = 1'b1; cache_hit = 1'b0; fetch_addr = 10'h111;
    cyc();                                   // REQ
    mem_gnt = 1'b1;
    cyc();                                   // WAIT
    mem_gnt = 1'b0; flush = 1'b1; fetch_valid = 1'b0;
    cyc();                                   // DRAIN
    flush = 1'b0;
    settle();
    check("m4_drain_stall", 32'(stall), 32'd0);
    check("m4_drain_req", 32'(mem_req), 32'd0);
    fetch_valid = 1'b1; fetch_addr = 10'h222;
    settle();
    check("m4_drain_miss_stall", 32'(stall), 32'd1);
    cyc();                                   // still DRAIN
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    settle();
    check("m4_drain_req2", 32'(mem_req), 32'd0);
    cyc();                                   // IDLE
    mem_rvalid = 1'b0; fetch_valid = 1'b0;
    settle();
    check("m4_idle_stall", 32'(stall), 32'd0);
    check("m4_wdata_kept", cache_wdata, 32'h12345678);
    check("m4_addr", 32'(mem_addr), 32'h111);
    cyc();
    mon_en = 1'b0;
    check("m4_update_cycles", 32'(upd_cnt), 32'd0);

    // 5: no response: mem_err rises ~255 cycles after gnt and stays
    fetch_valid = 1'b1; cache_hit = 1'b0; fetch_addr = 10'h200;
    cyc();                                   // REQ
    fetch_valid = 1'b0; mem_gnt = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      cyc();
      mem_gnt = 1'b0;
      settle();
      if (i == 250) check("m5_err_early", 32'(mem_err), 32'd0);
      if (i == 260) check("m5_err_set", 32'(mem_err), 32'd1);
    end
    check("m5_still_wait_stall", 32'(stall), 32'd1);
    check("m5_err_300", 32'(mem_err), 32'd1);
    flush = 1'b1;
    cyc();                                   // DRAIN
    flush = 1'b0; mem_rvalid = 1'b1;
    cyc();                                   // IDLE
    mem_rvalid = 1'b0;
    cyc();
    check("m5_err_sticky", 32'(mem_err), 32'd1);
    check("m5_idle_stall", 32'(stall), 32'd0);

    // 6: reset mid-WAIT clears everything; late rvalid ignored
    fetch_valid = 1'b1; cache_hit = 1'b0; fetch_addr = 10'h0AB;
    cyc();                                   // REQ
    fetch_valid = 1'b0; mem_gnt = 1'b1;
    cyc();                                   // WAIT
    mem_gnt = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("m6_rst_req", 32'(mem_req), 32'd0);
    check("m6_rst_addr", 32'(mem_addr), 32'd0);
    check("m6_rst_stall", 32'(stall), 32'd0);
    check("m6_rst_wdata", cache_wdata, 32'd0);
    check("m6_rst_err", 32'(mem_err), 32'd0);
    cyc();
    reset = 1'b0;
    mon_start();
    mem_rvalid = 1'b1; mem_rdata = 32'hBADC0DE5;
    cyc();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("m6_stray_update", 32'(cache_update), 32'd0);
      cyc();
    end
    mon_en = 1'b0;
    check("m6_stray_req_cycles", 32'(req_cnt), 32'd0);
    check("m6_stray_stall_cycles", 32'(stall_cnt), 32'd0);
    check("m6_stray_wdata", cache_wdata, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
